// File: rtl/dkongjr_obj_scan.sv
// dkongjr_obj_scan: per-line sprite scanner over a 96-entry object RAM
// (4 bytes per entry: Y, CODE, ATTR, X). DMA fills the RAM. A line-start
// pulse walks entries 0..95 and emits every sprite covering that line.
// Optional build macro DKONGJR_OBJ_DBLBUF_EN adds front/back RAM banks.
// Without it the scanner reads live RAM and yields the port to DMA.
//
// Object handshake: O_OBJ_VALID rises with X/CODE/ATTR/ROW already stable.
// Those outputs hold until a clock edge samples I_OBJ_READY high; that edge
// consumes the object. I_OBJ_READY has no effect while O_OBJ_VALID is low.
// A new line start or a reset drops O_OBJ_VALID without consuming.
module dkongjr_obj_scan (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic [9:0] I_DMA_AD,
  input  logic [7:0] I_DMA_DD,
  input  logic       I_DMA_CED,
  input  logic       I_LINE_START,
  input  logic [7:0] I_VPOS,
  output logic       O_OBJ_VALID,
  input  logic       I_OBJ_READY,
  output logic [7:0] O_OBJ_X,
  output logic [7:0] O_OBJ_CODE,
  output logic [7:0] O_OBJ_ATTR,
  output logic [3:0] O_OBJ_ROW,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_OVF,
  output logic [2:0] O_DBG_STATE
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_TEST, S_EMIT, S_END} state_t;

  state_t     state;
  logic [6:0] entry;
  logic [2:0] fcnt;       // bytes of the current entry already requested
  logic       cap_vld;    // rd_data holds a byte requested last cycle
  logic [1:0] cap_idx;
  logic [7:0] rd_data;
  logic [7:0] vpos_q;
  logic [7:0] ent_y, ent_code, ent_attr, ent_x;
  logic [4:0] hit_cnt;
  logic       dma_wr, rd_en, hit, adv;
  logic [8:0] rd_addr;
  logic [7:0] diff;

  assign dma_wr      = I_DMA_CED && (I_DMA_AD < 10'd384) && !I_RST;
  assign rd_addr     = {entry, fcnt[1:0]};
  assign diff        = vpos_q - ent_y;
  assign hit         = (diff[7:4] == 4'd0);
  assign adv         = ((state == S_TEST) && !hit) || ((state == S_EMIT) && I_OBJ_READY);
  assign O_DBG_STATE = state;

`ifdef DKONGJR_OBJ_DBLBUF_EN
  logic [7:0] mem [0:1][0:383];
  logic       front;
  logic       armed;
  logic       ced_q;
  logic       ced_fall;

  assign ced_fall = ced_q && !I_DMA_CED;
  // Banks are separate, so the scanner never waits on DMA.
  assign rd_en    = (state == S_FETCH) && (fcnt < 3'd4);

  // Bank select: a finished DMA burst arms a swap that only a line start applies.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      front <= 1'b0;
      armed <= 1'b0;
      ced_q <= 1'b0;
    end else begin
      ced_q <= I_DMA_CED;
      if (I_LINE_START) begin
        if (armed) front <= ~front;
        armed <= ced_fall;
      end else if (ced_fall) begin
        armed <= 1'b1;
      end
    end
  end

  // Object RAM: DMA fills the back bank, the scanner reads the front bank.
  always_ff @(posedge I_CLK) begin
    if (dma_wr) mem[~front][I_DMA_AD[8:0]] <= I_DMA_DD;
    if (rd_en) rd_data <= mem[front][rd_addr];
  end
`else
  logic [7:0] mem [0:383];

  // Single port: any DMA cycle takes the RAM and the fetch waits one cycle.
  assign rd_en = (state == S_FETCH) && (fcnt < 3'd4) && !I_DMA_CED;

  // Object RAM: DMA write wins the port, scanner reads with one cycle latency.
  always_ff @(posedge I_CLK) begin
    if (dma_wr) mem[I_DMA_AD[8:0]] <= I_DMA_DD;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

  // Scan FSM: fetch 4 bytes, test the line, emit on hit, advance or finish.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state       <= S_IDLE;
      entry       <= 7'd0;
      fcnt        <= 3'd0;
      cap_vld     <= 1'b0;
      cap_idx     <= 2'd0;
      vpos_q      <= 8'd0;
      ent_y       <= 8'd0;
      ent_code    <= 8'd0;
      ent_attr    <= 8'd0;
      ent_x       <= 8'd0;
      hit_cnt     <= 5'd0;
      O_OBJ_VALID <= 1'b0;
      O_OBJ_X     <= 8'd0;
      O_OBJ_CODE  <= 8'd0;
      O_OBJ_ATTR  <= 8'd0;
      O_OBJ_ROW   <= 4'd0;
      O_BUSY      <= 1'b0;
      O_DONE      <= 1'b0;
      O_OVF       <= 1'b0;
    end else if (I_LINE_START) begin
      state       <= S_FETCH;
      entry       <= 7'd0;
      fcnt        <= 3'd0;
      cap_vld     <= 1'b0;
      vpos_q      <= I_VPOS;
      hit_cnt     <= 5'd0;
      O_OBJ_VALID <= 1'b0;
      O_BUSY      <= 1'b1;
      O_DONE      <= 1'b0;
      O_OVF       <= 1'b0;
    end else begin
      O_DONE  <= 1'b0;
      cap_vld <= rd_en;
      if (rd_en) begin
        cap_idx <= fcnt[1:0];
        fcnt    <= fcnt + 3'd1;
      end
      if (cap_vld) begin
        case (cap_idx)
          2'd0:    ent_y    <= rd_data;
          2'd1:    ent_code <= rd_data;
          2'd2:    ent_attr <= rd_data;
          default: ent_x    <= rd_data;
        endcase
      end
      case (state)
        S_FETCH: if (cap_vld && cap_idx == 2'd3) state <= S_TEST;
        S_TEST: begin
          if (hit) begin
            if (hit_cnt == 5'd16) begin
              O_OVF  <= 1'b1;
              O_DONE <= 1'b1;
              state  <= S_END;
            end else begin
              O_OBJ_X     <= ent_x;
              O_OBJ_CODE  <= ent_code;
              O_OBJ_ATTR  <= ent_attr;
              O_OBJ_ROW   <= diff[3:0];
              O_OBJ_VALID <= 1'b1;
              hit_cnt     <= hit_cnt + 5'd1;
              state       <= S_EMIT;
            end
          end
        end
        S_EMIT: if (I_OBJ_READY) O_OBJ_VALID <= 1'b0;
        S_END: begin
          O_BUSY <= 1'b0;
          state  <= S_IDLE;
        end
        default: ;
      endcase
      if (adv) begin
        if (entry == 7'd95) begin
          O_DONE <= 1'b1;
          state  <= S_END;
        end else begin
          entry <= entry + 7'd1;
          fcnt  <= 3'd0;
          state <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_dkongjr_obj_scan.sv
// tb_dkongjr_obj_scan: directed and random line scans against a table-based
// reference of the object RAM, with a queue scoreboard fed at each line start.
module tb_dkongjr_obj_scan;

`ifdef DKONGJR_OBJ_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       I_RST, I_DMA_CED, I_LINE_START, I_OBJ_READY;
  logic [9:0] I_DMA_AD;
  logic [7:0] I_DMA_DD, I_VPOS;
  logic       O_OBJ_VALID, O_BUSY, O_DONE, O_OVF;
  logic [7:0] O_OBJ_X, O_OBJ_CODE, O_OBJ_ATTR;
  logic [3:0] O_OBJ_ROW;
  logic [2:0] dbg_state;

  dkongjr_obj_scan dut (
    .I_CLK(clk), .I_RST(I_RST),
    .I_DMA_AD(I_DMA_AD), .I_DMA_DD(I_DMA_DD), .I_DMA_CED(I_DMA_CED),
    .I_LINE_START(I_LINE_START), .I_VPOS(I_VPOS),
    .O_OBJ_VALID(O_OBJ_VALID), .I_OBJ_READY(I_OBJ_READY),
    .O_OBJ_X(O_OBJ_X), .O_OBJ_CODE(O_OBJ_CODE), .O_OBJ_ATTR(O_OBJ_ATTR),
    .O_OBJ_ROW(O_OBJ_ROW), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_OVF(O_OVF),
    .O_DBG_STATE(dbg_state)
  );

  // ---------------- reference state and scoreboard ----------------
  logic [28:0] exp_q[$];            // {is_done, x, code, attr, row} or {1, 0.., ovf}
  logic [7:0]  ref_mem [0:1][0:383];
  int          ref_front = 0;
  bit          ref_armed = 1'b0;
  logic [7:0]  tbl_y [0:95];
  logic [7:0]  tbl_c [0:95];
  logic [7:0]  tbl_a [0:95];
  logic [7:0]  tbl_x [0:95];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_mode = 0;      // 0 low, 1 high, 2 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_item(input string name, input logic [28:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_unexpected: got item 0x%0h, expected none", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Reference scan: every entry whose line offset (vpos - Y) mod 256 is under 16,
  // in entry order, at most 16 of them, then a done marker carrying overflow.
  task automatic push_scan(input logic [7:0] vpos);
    int hits = 0;
    bit ovf  = 1'b0;
    for (int e = 0; e < 96; e++) begin
      logic [7:0] d;
      d = vpos - ref_mem[ref_front][e*4];
      if (d < 8'd16) begin
        if (hits == 16) begin
          ovf = 1'b1;
          break;
        end
        exp_q.push_back({1'b0, ref_mem[ref_front][e*4+3], ref_mem[ref_front][e*4+1],
                         ref_mem[ref_front][e*4+2], d[3:0]});
        hits++;
      end
    end
    exp_q.push_back({1'b1, 27'd0, ovf});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!I_RST) begin
      if (O_OBJ_VALID && I_OBJ_READY)
        compare_item("emit", {1'b0, O_OBJ_X, O_OBJ_CODE, O_OBJ_ATTR, O_OBJ_ROW});
      if (O_DONE)
        compare_item("done", {1'b1, 27'd0, O_OVF});
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       I_OBJ_READY = 1'b0;
        1:       I_OBJ_READY = 1'b1;
        default: I_OBJ_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wbank();
    return DBL ? (ref_front ^ 1) : 0;
  endfunction

  task automatic dma_byte(input int addr, input logic [7:0] d);
    I_DMA_CED = 1'b1;
    I_DMA_AD  = 10'(addr);
    I_DMA_DD  = d;
    if (addr < 384) ref_mem[wbank()][addr] = d;
    tick();
  endtask

  task automatic dma_end();
    I_DMA_CED = 1'b0;
    tick();
    if (DBL) ref_armed = 1'b1;
  endtask

  task automatic fill_table();
    for (int i = 0; i < 384; i++) begin
      logic [7:0] v;
      case (i % 4)
        0:       v = tbl_y[i/4];
        1:       v = tbl_c[i/4];
        2:       v = tbl_a[i/4];
        default: v = tbl_x[i/4];
      endcase
      dma_byte(i, v);
    end
    dma_byte(10'h200, 8'h3C);   // beyond the RAM: must not alias entry 0
    dma_end();
  endtask

  task automatic set_table(input logic [7:0] y);
    for (int e = 0; e < 96; e++) begin
      tbl_y[e] = y;
      tbl_c[e] = 8'($urandom);
      tbl_a[e] = 8'($urandom);
      tbl_x[e] = 8'($urandom);
    end
  endtask

  task automatic line_start(input logic [7:0] vpos);
    if (DBL && ref_armed) begin
      ref_front = ref_front ^ 1;
      ref_armed = 1'b0;
    end
    push_scan(vpos);
    I_LINE_START = 1'b1;
    I_VPOS       = vpos;
    tick();
    I_LINE_START = 1'b0;
    I_VPOS       = 8'($urandom);
    check("busy_start", O_BUSY, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || O_BUSY) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) $display("scan did not finish, dbg state %0d", dbg_state);
    check("scan_drain", exp_q.size(), 0);
    check("scan_idle", O_BUSY, 0);
  endtask

  // Puts the table into the bank the next scan will read (both banks when banked).
  task automatic load_table();
    fill_table();
`ifdef DKONGJR_OBJ_DBLBUF_EN
    ready_mode = 2;
    line_start(8'h00);
    wait_idle();
    fill_table();
`endif
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 384; i++) ref_mem[b][i] = 8'h00;
    I_OBJ_READY  = 1'b0;
    I_RST        = 1'b1;
    I_DMA_CED    = 1'b1;          // DMA and line start under reset are both ignored
    I_DMA_AD     = 10'd0;
    I_DMA_DD     = 8'hAA;
    I_LINE_START = 1'b1;
    I_VPOS       = 8'h45;
    repeat (3) tick();
    check("rst_valid", O_OBJ_VALID, 0);
    check("rst_busy", O_BUSY, 0);
    check("rst_done", O_DONE, 0);
    check("rst_ovf", O_OVF, 0);
    check("rst_x", O_OBJ_X, 0);
    check("rst_code", O_OBJ_CODE, 0);
    check("rst_attr", O_OBJ_ATTR, 0);
    check("rst_row", O_OBJ_ROW, 0);
    I_RST = 1'b0;
    I_DMA_CED = 1'b0;
    I_LINE_START = 1'b0;
    tick();
    check("idle_after_rst", O_BUSY, 0);

    // single hit with row 5
    set_table(8'hF0);
    tbl_y[0] = 8'h40; tbl_c[0] = 8'h12; tbl_a[0] = 8'h05; tbl_x[0] = 8'h80;
    load_table();
    ready_mode = 2;
    line_start(8'h45);
    wait_idle();

    // wraparound hit, then a line just past the sprite
    set_table(8'hF0);
    tbl_y[3] = 8'hF8;
    load_table();
    line_start(8'h02);
    wait_idle();
    line_start(8'h08);
    wait_idle();

    // overflow: 20 candidates, only 16 emitted
    set_table(8'hF0);
    for (int e = 0; e < 20; e++) tbl_y[e] = 8'h10;
    load_table();
    ready_mode = 1;
    line_start(8'h10);
    wait_idle();
    tick();
    tick();
    check("ovf_hold", O_OVF, 1);

    // backpressure on the first hit, boundary rows, last entry
    set_table(8'hF0);
    tbl_y[2] = 8'h80; tbl_y[5] = 8'h7D; tbl_y[9] = 8'h79; tbl_y[30] = 8'h71;
    tbl_y[31] = 8'h70; tbl_y[60] = 8'h77; tbl_y[95] = 8'h7F;
    load_table();
    ready_mode = 0;
    line_start(8'h80);
    check("ovf_clear", O_OVF, 0);
    begin
      int n = 0;
      logic [27:0] snap;
      while (!O_OBJ_VALID && n < 2000) begin
        tick();
        n++;
      end
      check("first_valid", O_OBJ_VALID, 1);
      snap = {O_OBJ_X, O_OBJ_CODE, O_OBJ_ATTR, O_OBJ_ROW};
      for (int k = 0; k < 10; k++) begin
        tick();
        check("hold_stable", {O_OBJ_VALID, O_OBJ_X, O_OBJ_CODE, O_OBJ_ATTR, O_OBJ_ROW},
              {1'b1, snap});
      end
    end
    ready_mode = 2;
    wait_idle();

    // abort mid-scan and restart with a new line
    line_start(8'h80);
    repeat (100) tick();
    check("busy_before_abort", O_BUSY, 1);
    ready_mode = 0;
    tick();
    tick();
    exp_q.delete();
    line_start(8'h78);
    check("valid_dropped", O_OBJ_VALID, 0);
    ready_mode = 2;
    wait_idle();

    // random tables and lines
    for (int r = 0; r < 4; r++) begin
      logic [7:0] v;
      v = 8'($urandom);
      set_table(8'h00);
      for (int e = 0; e < 96; e++) tbl_y[e] = 8'(v - 8'($urandom_range(0, 24 + r * 60)));
      load_table();
      ready_mode = 2;
      line_start(v);
      wait_idle();
    end

    // DMA rewrites entry 0 Y while a scan runs
    set_table(8'hF0);
    tbl_y[0] = 8'h40;
    load_table();
    ready_mode = 1;
    line_start(8'h45);
    repeat (40) tick();
`ifdef DKONGJR_OBJ_DBLBUF_EN
    I_DMA_CED = 1'b1;
    I_DMA_AD  = 10'd0;
    I_DMA_DD  = 8'h43;
    ref_mem[wbank()][0] = 8'h43;
    wait_idle();
    line_start(8'h45);           // burst still open: old bank stays in front
    wait_idle();
    dma_end();
    line_start(8'h45);
    wait_idle();
`else
    dma_byte(0, 8'h43);
    dma_end();
    wait_idle();
    line_start(8'h45);
    wait_idle();
`endif

    // reset mid-scan, with DMA and line start in the same cycle
    set_table(8'h00);
    for (int e = 0; e < 96; e++) tbl_y[e] = 8'(8'h45 - 8'($urandom_range(0, 40)));
    tbl_y[1] = 8'h20;
    load_table();
    ready_mode = 2;
    line_start(8'h45);
    repeat (30) tick();
    ready_mode = 0;
    tick();
    I_RST        = 1'b1;
    I_DMA_CED    = 1'b1;
    I_DMA_AD     = 10'd4;
    I_DMA_DD     = 8'h45;
    I_LINE_START = 1'b1;
    I_VPOS       = 8'h45;
    tick();
    I_RST        = 1'b0;
    I_DMA_CED    = 1'b0;
    I_LINE_START = 1'b0;
    exp_q.delete();
    ref_front = 0;
    ref_armed = 1'b0;
    check("midrst_valid", O_OBJ_VALID, 0);
    check("midrst_busy", O_BUSY, 0);
    check("midrst_done", O_DONE, 0);
    ready_mode = 2;
    line_start(8'h45);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
